regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and sequencer for the 32x32 register file's single write port (we3/a3/wd3). Two write-back requesters (req0 = ALU result path, req1 = load/long-latency path) compete for the port through valid/ready handshakes. A round-robin grant selects the winner, and the winner's write is registered onto the register-file write port one cycle later. An optional pending-write scoreboard tracks destination registers claimed at issue, for hazard stalls in the decode stage.

## Interface
Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, write data width
- NREG, 32, number of architectural registers (2**ADDR_W)

Ports:
- clk_i  input  1  clock, rising edge
- reset_i  input  1  reset, asynchronous, active-low
- req0_valid_i  input  1  requester 0 has a write pending
- req0_addr_i  input  ADDR_W  requester 0 destination register
- req0_data_i  input  DATA_W  requester 0 write data
- req0_ready_o  output  1  requester 0 write accepted this cycle
- req1_valid_i / req1_addr_i / req1_data_i / req1_ready_o  as req0, for requester 1
- hold_i  input  1  block all grants this cycle (flush/freeze)
- claim_valid_i  input  1  issue stage claims a destination register
- claim_addr_i  input  ADDR_W  register being claimed
- rf_we_o  output  1  register file write enable (to we3)
- rf_addr_o  output  ADDR_W  register file write address (to a3)
- rf_data_o  output  DATA_W  register file write data (to wd3)
- busy_o  output  NREG  per-register pending-write bitmap; bit 0 always 0

## Operation
- **Transfer:** a transfer occurs when reqN_valid_i && reqN_ready_o. At most one ready is asserted per cycle.
- **Grant rules:**
  - hold_i=1: no grant; both readies are 0.
  - Exactly one valid: that requester is granted.
  - Both valid: the requester selected by the priority pointer prio (0 or 1) is granted.
- **Priority pointer:** after any transfer, prio moves to the non-granted requester. With no transfer, prio holds.
- **Handshake:** ready is combinational from valid, hold_i and prio. A requester keeps valid, addr and data stable until ready. Dropping valid before ready is legal, and the write is then lost.
- **Output stage:**
  - On a transfer: rf_we_o <= (addr != 0), rf_addr_o <= addr, rf_data_o <= data.
  - With no transfer: rf_we_o <= 0, and rf_addr_o/rf_data_o hold.
  - Writes to x0 are consumed (ready=1) but never drive rf_we_o.
- **Throughput:** the register file accepts every cycle, so the arbiter never back-pressures for its own output. One write per cycle is sustained.
- **Scoreboard (when enabled):**
  - claim_valid_i with claim_addr_i != 0 sets busy[claim_addr_i] at the next edge.
  - A transfer to addr != 0 clears busy[addr] at the same edge rf_we_o is loaded.
  - Same-cycle claim and retire of the same address: set wins, because the new producer is outstanding.
  - A claim to an already-busy register is legal and keeps it busy.

## Timing
- Reset (reset_i low, asynchronous): rf_we_o=0, rf_addr_o=0, rf_data_o=0, prio=0, busy_o=0. Readies are combinational and evaluate normally once reset deasserts.
- Latency is 1 cycle, from the accepting edge to rf_we_o=1. The register file commits on the following edge.
- Reset asserted mid-stream: an in-flight rf_we_o clears immediately and that write is lost. Requesters must re-present their writes after reset.
- hold_i is sampled each cycle and does not disturb an already-registered rf_we_o.

## Configuration
- Macro: REGFILE_WB_ARB_SCOREBOARD_EN.
  - Defined: busy flops and set/clear logic are built as described above.
  - Undefined: busy_o is tied to 0, and claim_valid_i/claim_addr_i are ignored (no flops).
- Arbitration behaviour is identical in both builds.

## Test plan
- **Reset values:** assert reset_i=0 mid-run with rf_we_o=1 -> rf_we_o=0, rf_addr_o=0, busy_o=0 immediately; after release, both valid -> req0 granted first (prio=0).
- **Contention:** req0 (addr 5, 0xAAAA_0000) and req1 (addr 6, 0x5555_0000) valid and held for 4 cycles -> grants alternate 0,1,0,1. rf_addr_o then reads 5,6,5,6, one cycle behind each grant.
- **Single requester and x0:** only req1 valid with addr 0, data 0xDEAD_BEEF -> req1_ready_o=1, rf_we_o stays 0. Then req1 addr 7 -> rf_we_o=1, rf_addr_o=7 next cycle.
- **hold_i:** both valid with hold_i=1 for 3 cycles -> no readies, rf_we_o=0, prio unchanged. Release -> the prio requester is granted.
- **Scoreboard (macro on):**
  - Claim addr 9 -> busy_o[9]=1 next cycle.
  - req0 writes addr 9 -> busy_o[9]=0 with rf_we_o=1.
  - Claim 9 in the same cycle req0 retires 9 -> busy_o[9] stays 1.
  - Claim addr 0 -> busy_o[0] stays 0.
- **Scoreboard (macro off):** same stimulus as the macro-on scenario -> busy_o=0 throughout, and arbitration traces are identical to the macro-on build.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two result producers, the issue stage and the
// register-file write port. The arbiter uses the slave modport.
interface regfile_wb_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int NREG   = 32
);
    logic              req0_valid_i;
    logic [ADDR_W-1:0] req0_addr_i;
    logic [DATA_W-1:0] req0_data_i;
    logic              req0_ready_o;
    logic              req1_valid_i;
    logic [ADDR_W-1:0] req1_addr_i;
    logic [DATA_W-1:0] req1_data_i;
    logic              req1_ready_o;
    logic              hold_i;
    logic              claim_valid_i;
    logic [ADDR_W-1:0] claim_addr_i;
    logic              rf_we_o;
    logic [ADDR_W-1:0] rf_addr_o;
    logic [DATA_W-1:0] rf_data_o;
    logic [NREG-1:0]   busy_o;

    modport master (
        output req0_valid_i, req0_addr_i, req0_data_i,
        output req1_valid_i, req1_addr_i, req1_data_i,
        output hold_i, claim_valid_i, claim_addr_i,
        input  req0_ready_o, req1_ready_o,
        input  rf_we_o, rf_addr_o, rf_data_o, busy_o
    );

    modport slave (
        input  req0_valid_i, req0_addr_i, req0_data_i,
        input  req1_valid_i, req1_addr_i, req1_data_i,
        input  hold_i, claim_valid_i, claim_addr_i,
        output req0_ready_o, req1_ready_o,
        output rf_we_o, rf_addr_o, rf_data_o, busy_o
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter feeding the register-file write port one cycle after grant.
// Optional pending-write scoreboard built when REGFILE_WB_ARB_SCOREBOARD_EN is defined.
module regfile_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int NREG   = 2 ** ADDR_W
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    regfile_wb_arbiter_if.slave  wb
);
    logic              grant0, grant1, xfer;
    logic              prio_q, prio_d;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;

    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        if (!wb.hold_i) begin
            if (wb.req0_valid_i && wb.req1_valid_i) begin
                grant0 = !prio_q;
                grant1 = prio_q;
            end else begin
                grant0 = wb.req0_valid_i;
                grant1 = wb.req1_valid_i;
            end
        end
        xfer      = grant0 | grant1;
        sel_addr  = grant1 ? wb.req1_addr_i : wb.req0_addr_i;
        sel_data  = grant1 ? wb.req1_data_i : wb.req0_data_i;

        prio_d    = prio_q;
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (xfer) begin
            // Pointer moves to the loser; x0 writes are consumed but never enabled.
            prio_d    = grant0;
            rf_we_d   = |sel_addr;
            rf_addr_d = sel_addr;
            rf_data_d = sel_data;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            prio_q    <= 1'b0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            prio_q    <= prio_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign wb.req0_ready_o = grant0;
    assign wb.req1_ready_o = grant1;
    assign wb.rf_we_o      = rf_we_q;
    assign wb.rf_addr_o    = rf_addr_q;
    assign wb.rf_data_o    = rf_data_q;

`ifdef REGFILE_WB_ARB_SCOREBOARD_EN
    logic [NREG-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (xfer && (sel_addr != '0))
            busy_d[sel_addr] = 1'b0;
        // Applied after the retire clear: a fresh claim means a newer producer is outstanding.
        if (wb.claim_valid_i && (wb.claim_addr_i != '0))
            busy_d[wb.claim_addr_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) busy_q <= '0;
        else          busy_q <= busy_d;
    end

    assign wb.busy_o = busy_q;
`else
    logic unused_claim;
    assign unused_claim = ^{wb.claim_valid_i, wb.claim_addr_i};
    assign wb.busy_o    = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level model of grants, write-back and busy bits.
module tb_regfile_wb_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 32;
`ifdef REGFILE_WB_ARB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic clk, rst_n;
    int   checks, failures;

    regfile_wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .NREG(NR)) bus ();
    regfile_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NREG(NR)) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .wb      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: who has priority, what the write port shows, which regs are pending.
    int            m_prio;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [NR-1:0] m_busy;
    bit            g0, g1;

    task automatic model_reset();
        m_prio = 0; m_we = 0; m_addr = '0; m_data = '0; m_busy = '0;
    endtask

    // Decide the winner from the current inputs.
    task automatic eval();
        int winner;
        winner = -1;
        if (!bus.hold_i) begin
            if (bus.req0_valid_i && bus.req1_valid_i) winner = m_prio;
            else if (bus.req0_valid_i)                winner = 0;
            else if (bus.req1_valid_i)                winner = 1;
        end
        g0 = (winner == 0);
        g1 = (winner == 1);
    endtask

    // Advance one clock, applying the winner's write and claims to the model; returns at negedge.
    task automatic edge_step();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        eval();
        a = g1 ? bus.req1_addr_i : bus.req0_addr_i;
        d = g1 ? bus.req1_data_i : bus.req0_data_i;
        @(posedge clk);
        if (g0 || g1) begin
            m_we = (a != 0); m_addr = a; m_data = d;
            m_prio = g0 ? 1 : 0;
            if (SB && a != 0) m_busy[a] = 1'b0;
        end else begin
            m_we = 0;
        end
        if (SB && bus.claim_valid_i && bus.claim_addr_i != 0) m_busy[bus.claim_addr_i] = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic h, input logic cv, input logic [AW-1:0] ca);
        bus.req0_valid_i = v0; bus.req0_addr_i = a0; bus.req0_data_i = d0;
        bus.req1_valid_i = v1; bus.req1_addr_i = a1; bus.req1_data_i = d1;
        bus.hold_i = h; bus.claim_valid_i = cv; bus.claim_addr_i = ca;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.rf_we_o !== 1'b0 || bus.rf_addr_o !== '0 || bus.rf_data_o !== '0 || bus.busy_o !== '0) begin
            failures++;
            $display("FAIL reset_values: we=%b addr=%0d data=%h busy=%h want 0", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o, bus.busy_o);
        end
        rst_n = 1'b1;
    endtask

    // Reset lands while a write is on the port; the write vanishes, then req0 wins first.
    task automatic test_reset_mid();
        drive(1, 5'd3, 32'h1234_5678, 0, 0, 0, 0, 1, 5'd12);
        edge_step();
        checks++;
        if (bus.rf_we_o !== 1'b1 || bus.busy_o !== m_busy) begin
            failures++;
            $display("FAIL pre_reset_write: we=%b busy=%h want we=1 busy=%h", bus.rf_we_o, bus.busy_o, m_busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rf_we_o !== 1'b0 || bus.rf_addr_o !== '0 || bus.busy_o !== '0) begin
            failures++;
            $display("FAIL reset_mid_clear: we=%b addr=%0d busy=%h want 0", bus.rf_we_o, bus.rf_addr_o, bus.busy_o);
        end
        model_reset();
        drive(1, 5'd5, 32'hAAAA_0000, 1, 5'd6, 32'h5555_0000, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.req0_ready_o !== 1'b1 || bus.req1_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_prio: ready=%b%b want 01", bus.req1_ready_o, bus.req0_ready_o);
        end
    endtask

    task automatic test_contention();
        for (int k = 0; k < 4; k++) begin
            eval();
            checks++;
            if (bus.req0_ready_o !== (k % 2 == 0) || bus.req1_ready_o !== (k % 2 == 1) || g0 !== (k % 2 == 0)) begin
                failures++;
                $display("FAIL contention_grant k=%0d: ready1/0=%b%b want grant %0d", k, bus.req1_ready_o, bus.req0_ready_o, k % 2);
            end
            edge_step();
            checks++;
            if (bus.rf_we_o !== 1'b1 || bus.rf_addr_o !== ((k % 2 == 0) ? 5'd5 : 5'd6) ||
                bus.rf_data_o !== ((k % 2 == 0) ? 32'hAAAA_0000 : 32'h5555_0000)) begin
                failures++;
                $display("FAIL contention_out k=%0d: we=%b addr=%0d data=%h", k, bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o);
            end
        end
    endtask

    task automatic test_x0();
        drive(0, 0, 0, 1, 5'd0, 32'hDEAD_BEEF, 0, 0, 0);
        #1;
        checks++;
        if (bus.req1_ready_o !== 1'b1 || bus.req0_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL x0_ready: ready1/0=%b%b want 10", bus.req1_ready_o, bus.req0_ready_o);
        end
        edge_step();
        checks++;
        if (bus.rf_we_o !== 1'b0 || bus.rf_addr_o !== 5'd0 || bus.rf_data_o !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL x0_no_write: we=%b addr=%0d data=%h want we=0 addr=0 data=deadbeef", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o);
        end
        drive(0, 0, 0, 1, 5'd7, 32'h0000_0777, 0, 0, 0);
        edge_step();
        checks++;
        if (bus.rf_we_o !== 1'b1 || bus.rf_addr_o !== 5'd7 || bus.rf_data_o !== 32'h0000_0777) begin
            failures++;
            $display("FAIL single_req1: we=%b addr=%0d data=%h want we=1 addr=7", bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o);
        end
    endtask

    task automatic test_hold();
        int p;
        p = m_prio;
        drive(1, 5'd10, 32'h0A0A_0A0A, 1, 5'd11, 32'h0B0B_0B0B, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (bus.req0_ready_o !== 1'b0 || bus.req1_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL hold_ready k=%0d: ready1/0=%b%b want 00", k, bus.req1_ready_o, bus.req0_ready_o);
            end
            edge_step();
            checks++;
            if (bus.rf_we_o !== 1'b0) begin
                failures++;
                $display("FAIL hold_we k=%0d: we=%b want 0", k, bus.rf_we_o);
            end
        end
        bus.hold_i = 1'b0;
        #1;
        checks++;
        if (bus.req0_ready_o !== (p == 0) || bus.req1_ready_o !== (p == 1)) begin
            failures++;
            $display("FAIL hold_release: ready1/0=%b%b want grant %0d", bus.req1_ready_o, bus.req0_ready_o, p);
        end
        edge_step();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        for (int k = 0; k < 4; k++) begin
            d = $urandom;
            drive(1, 5'(k + 1), d, 0, 0, 0, 0, 0, 0);
            edge_step();
            checks++;
            if (bus.rf_we_o !== 1'b1 || bus.rf_addr_o !== 5'(k + 1) || bus.rf_data_o !== d) begin
                failures++;
                $display("FAIL back_to_back k=%0d: we=%b addr=%0d data=%h want addr=%0d data=%h", k, bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o, k + 1, d);
            end
        end
    endtask

    task automatic test_scoreboard();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd9);
        edge_step();
        checks++;
        if (bus.busy_o[9] !== SB || bus.busy_o !== m_busy) begin
            failures++;
            $display("FAIL sb_claim: busy=%h want %h", bus.busy_o, m_busy);
        end
        drive(1, 5'd9, 32'h9999_0000, 0, 0, 0, 0, 0, 0);
        edge_step();
        checks++;
        if (bus.busy_o[9] !== 1'b0 || bus.rf_we_o !== 1'b1 || bus.busy_o !== m_busy) begin
            failures++;
            $display("FAIL sb_retire: busy=%h we=%b want busy=%h we=1", bus.busy_o, bus.rf_we_o, m_busy);
        end
        drive(1, 5'd9, 32'h9999_0001, 0, 0, 0, 0, 1, 5'd9);
        edge_step();
        checks++;
        if (bus.busy_o[9] !== SB || bus.rf_we_o !== 1'b1 || bus.busy_o !== m_busy) begin
            failures++;
            $display("FAIL sb_set_wins: busy=%h we=%b want busy=%h", bus.busy_o, bus.rf_we_o, m_busy);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5'd0);
        edge_step();
        checks++;
        if (bus.busy_o[0] !== 1'b0 || bus.busy_o !== m_busy) begin
            failures++;
            $display("FAIL sb_claim_x0: busy=%h want %h", bus.busy_o, m_busy);
        end
    endtask

    // Requesters hold a request until accepted, occasionally withdrawing it.
    task automatic test_random();
        logic          v0, v1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        bit            t0, t1;
        v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0; t0 = 0; t1 = 0;
        for (int c = 0; c < 400; c++) begin
            if (!v0 || t0) begin v0 = ($urandom % 4) != 0; a0 = 5'($urandom); d0 = $urandom; end
            else if ($urandom % 16 == 0) v0 = 0;
            if (!v1 || t1) begin v1 = ($urandom % 3) != 0; a1 = 5'($urandom); d1 = $urandom; end
            else if ($urandom % 16 == 0) v1 = 0;
            drive(v0, a0, d0, v1, a1, d1, ($urandom % 5) == 0, ($urandom % 3) == 0, 5'($urandom));
            #1;
            eval();
            t0 = g0; t1 = g1;
            checks++;
            if (bus.req0_ready_o !== g0 || bus.req1_ready_o !== g1) begin
                failures++;
                $display("FAIL rand_ready c=%0d: ready1/0=%b%b want %b%b", c, bus.req1_ready_o, bus.req0_ready_o, g1, g0);
            end
            edge_step();
            checks++;
            if (bus.rf_we_o !== m_we || bus.rf_addr_o !== m_addr || bus.rf_data_o !== m_data || bus.busy_o !== m_busy) begin
                failures++;
                $display("FAIL rand_out c=%0d: we=%b addr=%0d data=%h busy=%h want we=%b addr=%0d data=%h busy=%h",
                         c, bus.rf_we_o, bus.rf_addr_o, bus.rf_data_o, bus.busy_o, m_we, m_addr, m_data, m_busy);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        @(negedge clk);
        test_reset_mid();
        test_contention();
        test_x0();
        test_hold();
        test_back_to_back();
        test_scoreboard();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
